// File: rtl/dm_load_unit.sv
// Data-memory load unit: issues word reads for M-stage loads over a req/ack
// handshake, stalls the pipeline meanwhile, and extracts/extends the result.
module dm_load_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_load,
  input  logic [31:0] M_addr,
  input  logic [2:0]  M_load_type,
  input  logic        flush,
  output logic        stall_out,
  output logic        exc_adel,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] W_ld_data,
  output logic        W_ld_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  state_t      state_q, state_d;
  logic [29:0] word_q, word_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] data_q, data_d;

  logic        type_valid;
  logic        misaligned;
  logic        accept;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

  assign type_valid = (M_load_type <= LT_LBU);

  always_comb begin
    misaligned = 1'b0;
    case (M_load_type)
      LT_LW:         misaligned = (M_addr[1:0] != 2'b00);
      LT_LH, LT_LHU: misaligned = M_addr[0];
      default:       misaligned = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && M_load && type_valid && !misaligned && !flush;

  // Lane selection uses the latched offset, not the live M-stage address.
  always_comb begin
    sel_byte = 8'h00;
    case (off_q)
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    ext_data = mem_rdata;
    case (type_q)
      LT_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  ext_data = {16'h0000, sel_half};
      LT_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  ext_data = {24'h000000, sel_byte};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    off_d     = off_q;
    type_d    = type_q;
    data_d    = data_q;
    stall_out = 1'b0;
    exc_adel  = 1'b0;
    case (state_q)
      S_IDLE: begin
        exc_adel = M_load && type_valid && misaligned;
        if (accept) begin
          state_d   = S_WAIT;
          word_d    = M_addr[31:2];
          off_d     = M_addr[1:0];
          type_d    = M_load_type;
          stall_out = 1'b1;
        end
      end
      S_WAIT: begin
        stall_out = 1'b1;
        // A flush coinciding with the ack discards the data outright.
        if (flush) begin
          state_d = mem_ack ? S_IDLE : S_DRAIN;
        end else if (mem_ack) begin
          data_d  = ext_data;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall_out = M_load;
        if (mem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= 30'd0;
      off_q   <= 2'd0;
      type_q  <= 3'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      off_q   <= off_d;
      type_q  <= type_d;
      data_q  <= data_d;
    end
  end

  assign mem_req    = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign mem_addr   = {word_q, 2'b00};
  assign W_ld_data  = data_q;
  assign W_ld_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit: loads, extraction, AdEL, flush/drain, reset.
module tb_dm_load_unit;

  logic        clk;
  logic        reset;
  logic        M_load;
  logic [31:0] M_addr;
  logic [2:0]  M_load_type;
  logic        flush;
  logic        stall_out;
  logic        exc_adel;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] W_ld_data;
  logic        W_ld_valid;

  int checks = 0;
  int errors = 0;

  dm_load_unit dut (
    .clk         (clk),
    .reset       (reset),
    .M_load      (M_load),
    .M_addr      (M_addr),
    .M_load_type (M_load_type),
    .flush       (flush),
    .stall_out   (stall_out),
    .exc_adel    (exc_adel),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .W_ld_data   (W_ld_data),
    .W_ld_valid  (W_ld_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load: accept cycle, lat request cycles (ack on the last), DONE cycle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] ltype,
                         input logic [31:0] rdata, input int lat, input logic [31:0] exp);
    M_load = 1'b1; M_addr = addr; M_load_type = ltype; mem_ack = 1'b0;
    #1;
    chk({tag, "_acc_stall"}, {31'd0, stall_out}, 32'd1);
    chk({tag, "_acc_req"}, {31'd0, mem_req}, 32'd0);
    step();
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      #1;
      chk({tag, "_wait_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_wait_addr"}, mem_addr, {addr[31:2], 2'b00});
      chk({tag, "_wait_stall"}, {31'd0, stall_out}, 32'd1);
      chk({tag, "_wait_valid"}, {31'd0, W_ld_valid}, 32'd0);
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    #1;
    chk({tag, "_done_valid"}, {31'd0, W_ld_valid}, 32'd1);
    chk({tag, "_done_data"}, W_ld_data, exp);
    chk({tag, "_done_stall"}, {31'd0, stall_out}, 32'd0);
    M_load = 1'b0;
    step();
    chk({tag, "_post_valid"}, {31'd0, W_ld_valid}, 32'd0);
    chk({tag, "_post_req"}, {31'd0, mem_req}, 32'd0);
    $display("load %s addr=%h type=%0d lat=%0d data=%h", tag, addr, ltype, lat, W_ld_data);
  endtask

  initial begin
    reset = 1'b0; M_load = 1'b0; M_addr = 32'd0; M_load_type = 3'd0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", W_ld_data, 32'd0);
    chk("rst_valid", {31'd0, W_ld_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    $display("reset state checked");
    reset = 1'b1;
    step();

    do_load("lw", 32'h0000_1004, 3'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    do_load("lb3", 32'h0000_1003, 3'd3, 32'h8070_F001, 1, 32'hFFFF_FF80);
    do_load("lbu3", 32'h0000_1003, 3'd4, 32'h8070_F001, 1, 32'h0000_0080);
    do_load("lb1", 32'h0000_1001, 3'd3, 32'h8070_F001, 1, 32'hFFFF_FFF0);
    do_load("lb0", 32'h0000_1000, 3'd3, 32'h8070_F001, 1, 32'h0000_0001);
    do_load("lbu2", 32'h0000_1002, 3'd4, 32'h8070_F001, 1, 32'h0000_0070);
    do_load("lh2", 32'h0000_1002, 3'd1, 32'h8070_F001, 1, 32'hFFFF_8070);
    do_load("lhu0", 32'h0000_1000, 3'd2, 32'h8070_F001, 1, 32'h0000_F001);
    do_load("lhu2", 32'h0000_1002, 3'd2, 32'h8070_F001, 1, 32'h0000_8070);
    do_load("lh0", 32'h0000_1000, 3'd1, 32'h8070_F001, 1, 32'hFFFF_F001);

    // Misaligned loads raise AdEL without requesting.
    M_load = 1'b1; M_addr = 32'h0000_1002; M_load_type = 3'd0;
    #1;
    chk("adel_lw_exc", {31'd0, exc_adel}, 32'd1);
    chk("adel_lw_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("adel_lw_req", {31'd0, mem_req}, 32'd0);
    M_addr = 32'h0000_1001; M_load_type = 3'd1;
    #1;
    chk("adel_lh_exc", {31'd0, exc_adel}, 32'd1);
    chk("adel_lh_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("adel_lh_req", {31'd0, mem_req}, 32'd0);
    M_addr = 32'h0000_1000; M_load_type = 3'd5;
    #1;
    chk("rsv_exc", {31'd0, exc_adel}, 32'd0);
    chk("rsv_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("rsv_req", {31'd0, mem_req}, 32'd0);
    M_load = 1'b0;
    $display("misaligned/reserved checks done");
    M_addr = 32'h0000_1003; M_load_type = 3'd3;
    #1;
    chk("lb_aligned_exc", {31'd0, exc_adel}, 32'd0);
    do_load("lb_al", 32'h0000_1003, 3'd3, 32'h1122_3344, 1, 32'h0000_0011);

    do_load("lw_slow", 32'h0000_2000, 3'd0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);

    // Flush in WAIT before ack -> DRAIN holds request until ack.
    M_load = 1'b1; M_addr = 32'h0000_3008; M_load_type = 3'd0;
    step();
    #1;
    chk("fl_wait_req", {31'd0, mem_req}, 32'd1);
    step();
    flush = 1'b1;
    #1;
    chk("fl_flush_stall", {31'd0, stall_out}, 32'd1);
    step();
    flush = 1'b0; M_load = 1'b0;
    #1;
    chk("fl_drain_req", {31'd0, mem_req}, 32'd1);
    chk("fl_drain_addr", mem_addr, 32'h0000_3008);
    chk("fl_drain_stall0", {31'd0, stall_out}, 32'd0);
    M_load = 1'b1;
    #1;
    chk("fl_drain_stall1", {31'd0, stall_out}, 32'd1);
    M_load = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("fl_ack_req", {31'd0, mem_req}, 32'd1);
    chk("fl_ack_valid", {31'd0, W_ld_valid}, 32'd0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("fl_idle_req", {31'd0, mem_req}, 32'd0);
    chk("fl_idle_valid", {31'd0, W_ld_valid}, 32'd0);
    chk("fl_idle_data", W_ld_data, 32'hCAFE_F00D);
    $display("flush-before-ack drain done data=%h", W_ld_data);

    // Flush and ack together: straight back to IDLE, no pulse.
    M_load = 1'b1; M_addr = 32'h0000_4000; M_load_type = 3'd0;
    step();
    M_load = 1'b0; flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h8765_4321;
    step();
    flush = 1'b0; mem_ack = 1'b0;
    #1;
    chk("flack_valid", {31'd0, W_ld_valid}, 32'd0);
    chk("flack_req", {31'd0, mem_req}, 32'd0);
    chk("flack_data", W_ld_data, 32'hCAFE_F00D);
    $display("flush+ack same cycle done");

    // Reset mid-WAIT drops everything asynchronously.
    M_load = 1'b1; M_addr = 32'h0000_5004; M_load_type = 3'd0;
    step();
    M_load = 1'b0;
    #1;
    chk("rw_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_req", {31'd0, mem_req}, 32'd0);
    chk("rw_addr", mem_addr, 32'd0);
    chk("rw_data", W_ld_data, 32'd0);
    chk("rw_stall", {31'd0, stall_out}, 32'd0);
    step();
    reset = 1'b1;
    step();
    $display("reset mid-wait done");
    do_load("lw_after_rst", 32'h0000_6008, 3'd0, 32'hA5A5_0F0F, 2, 32'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
